// File: rtl/imm_ext_pipe.sv
// Immediate extender with a two-slot skid buffer: the extension is computed on
// the input side so each slot stores the final result alongside its tag.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occ
);

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic             main_valid_reg;
    logic [OUT_W-1:0] main_data_reg;
    logic [TAG_W-1:0] main_tag_reg;
    logic             skid_valid_reg;
    logic [OUT_W-1:0] skid_data_reg;
    logic [TAG_W-1:0] skid_tag_reg;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_free;

    always_comb begin
        zext     = OUT_W'(in_imm);
        sext     = OUT_W'($signed(in_imm));
        ext_next = zext;
        case (in_mode)
            MODE_ZERO:   ext_next = zext;
            MODE_SIGN:   ext_next = sext;
            MODE_UPPER:  ext_next = zext << (OUT_W - IN_W);
            MODE_BRANCH: ext_next = sext << SHIFT;
            default:     ext_next = zext;
        endcase
    end

    // in_ready depends only on the skid flag, so out_ready never reaches it.
    assign in_ready  = rst_n & ~skid_valid_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_reg & out_ready;
    assign main_free = ~main_valid_reg | out_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_tag_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_tag_reg   <= '0;
        end else begin
            if (main_free) begin
                // A full skid always refills MAIN first to preserve order.
                if (skid_valid_reg) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= skid_data_reg;
                    main_tag_reg   <= skid_tag_reg;
                end else if (in_fire) begin
                    main_valid_reg <= 1'b1;
                    main_data_reg  <= ext_next;
                    main_tag_reg   <= in_tag;
                end else begin
                    main_valid_reg <= 1'b0;
                end
            end

            if (in_fire && !main_free) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= ext_next;
                skid_tag_reg   <= in_tag;
            end else if (out_fire && skid_valid_reg) begin
                skid_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_tag   = main_tag_reg;
    assign occ       = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning immediate field width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, meaning extended result width; legal range is OUT_W >= IN_W + SHIFT.
REQ-003 SHALL have parameter SHIFT, default 2, meaning left-shift amount for branch-offset mode.
REQ-004 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each item.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream item present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an item this cycle.
REQ-009 SHALL have port in_imm, input, IN_W bits: raw immediate.
REQ-010 SHALL have port in_mode, input, 2 bits: extension mode selector.
REQ-011 SHALL have port in_tag, input, TAG_W bits: sideband tag, such as a destination register index.
REQ-012 SHALL have port out_valid, output, 1 bit: result present.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out_data, output, OUT_W bits: extended result.
REQ-015 SHALL have port out_tag, output, TAG_W bits: tag of the presented result.
REQ-016 SHALL have port occ, output, 2 bits: number of items held, 0 to 2.

Function
REQ-017 SHALL treat mode 00 (ZERO) as in_imm zero-extended to OUT_W.
REQ-018 SHALL treat mode 01 (SIGN) as in_imm sign-extended from bit IN_W-1 to OUT_W.
REQ-019 SHALL treat mode 10 (UPPER) as in_imm placed in bits OUT_W-1..OUT_W-IN_W, with all lower bits 0.
REQ-020 SHALL treat mode 11 (BRANCH) as in_imm sign-extended, then shifted left by SHIFT, then truncated to OUT_W.
REQ-021 SHALL compute the extension before registering, so the stored item holds the final out_data value.
REQ-022 SHALL accept an input transfer only on a cycle where in_valid, in_ready and rst_n are all 1.
REQ-023 SHALL complete an output transfer on a cycle where out_valid and out_ready are both 1.
REQ-024 SHALL hold two storage slots: MAIN, which drives out_*, and SKID.
REQ-025 SHALL drive in_ready = rst_n AND (SKID empty), derived only from registered state, with no combinational path from out_ready.
REQ-026 SHALL load an accepted item into MAIN when MAIN is empty or MAIN is draining this cycle and SKID is empty, giving 1-cycle latency (accepted at edge N, out_valid at N+1).
REQ-027 SHALL load an accepted item into SKID when MAIN is full and not draining this cycle.
REQ-028 SHALL move SKID into MAIN when MAIN drains while SKID is full, leaving SKID empty; in_ready returns to 1 on the next cycle.
REQ-029 SHALL sustain throughput of 1 item per cycle while out_ready stays 1.
REQ-030 SHALL deliver items strictly in acceptance order, with no loss and no duplication.
REQ-031 SHALL hold out_data and out_tag stable while out_valid=1 and out_ready=0.
REQ-032 SHALL clear out_valid on the edge after the last item drains, when no new item is accepted.
REQ-033 SHALL make occ equal the registered count of valid slots.
REQ-034 SHALL never allow occ to exceed 2; an in_valid assertion while in_ready=0 is ignored, with no state change.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge, clear MAIN and SKID valid flags, out_valid=0, occ=0, and reset out_data and out_tag to 0.
REQ-036 SHALL drive in_ready=0 while rst_n=0 and in_ready=1 on the first cycle after release.
REQ-037 SHALL discard all in-flight items when reset is asserted mid-operation; none are presented after release.

Verification
REQ-038 SHALL cover: defaults, mode 00, imm 0x8001, out_ready=1 -> out_data 0x00008001 one cycle later, tag echoed.
REQ-039 SHALL cover: mode 01, imm 0x8001 -> 0xFFFF8001; mode 01, imm 0x7FFF -> 0x00007FFF.
REQ-040 SHALL cover: mode 10, imm 0x1234 -> 0x12340000; mode 11, imm 0xFFFF -> 0xFFFFFFFC; mode 11, imm 0x0004 -> 0x00000010.
REQ-041 SHALL cover: out_ready=0, send A (tag 1) then B (tag 2) -> occ=2, in_ready=0, C held off; raise out_ready -> A, B, C in order with no bubble after B.
REQ-042 SHALL cover: back-to-back stream of 8 items with out_ready=1 -> 8 outputs on consecutive cycles, occ stays at most 1.
REQ-043 SHALL cover: occ=2, assert rst_n=0 for one cycle -> out_valid=0, occ=0, in_ready=1 after release, A and B never appear.
